// File: rtl/frame_fifo_pkg.sv
// frame_fifo_pkg: shared types and helpers for the frame-aware FIFO.
package frame_fifo_pkg;

    // Smallest legal FIFO depth.
    localparam int MIN_DEPTH = 4;

    // Framing flags stored alongside each data word.
    typedef struct packed {
        logic sof;
        logic eof;
    } flags_t;

    // Modulo-2^pw difference of two pointers (pointers carry a wrap bit).
    function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int          pw);
        logic [31:0] mask;
        mask = (32'd1 << pw) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/frame_fifo_ram.sv
// frame_fifo_ram: simple dual-port RAM, one write port, one synchronous
// read port. Only the read data register is reset; the array is not.
module frame_fifo_ram #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read data holds until the next read.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    // Registered read port.
    always_ff @(posedge clock) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_fifo.sv
// frame_fifo: single-clock FIFO storing {sof, eof, data} per entry, with a
// complete-frame counter and fill level.
// Optional macro FRAME_DROP_EN: store-and-forward; only committed (EOF
// written) frames are readable, and overflowed or restarted frames are
// dropped with a one-cycle drop pulse.
module frame_fifo
    import frame_fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 1024,
    parameter int FRAME_CNT_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       sof_in,
    input  logic                       eof_in,
    output logic                       full,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       sof_out,
    output logic                       eof_out,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [PW-1:0]              DEPTH_P = PW'(DEPTH);
    localparam logic [FRAME_CNT_WIDTH-1:0] FC_MAX  = '1;

    if (DEPTH < MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("frame_fifo: DEPTH must be a power of 2 and >= %0d", MIN_DEPTH);
    end

    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [FRAME_CNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [PW-1:0]              level_w;
    logic [PW-1:0]              wr_addr;
    logic                       wr_we;
    logic                       rd_acc;
    logic                       fc_inc, fc_dec;
    logic [EW-1:0]              rdata;
    flags_t                     wr_flags, rd_flags;

    // EOF bit per slot, mirrored from the RAM so frame_count can update on
    // the same edge as the read instead of waiting for the registered data.
    logic [DEPTH-1:0]           eof_map_q;

    assign level_w = PW'(ptr_diff(32'(wr_ptr_q), 32'(rd_ptr_q), PW));
    assign level   = level_w;
    assign full    = (level_w == DEPTH_P);
    assign rd_acc  = rd_en && !empty;
    assign fc_dec  = rd_acc && eof_map_q[rd_ptr_q[AW-1:0]];

`ifdef FRAME_DROP_EN
    logic [PW-1:0] commit_q, commit_d;
    logic          discard_q, discard_d;
    logic          drop_q, drop_d;

    // Only committed entries are visible to the reader.
    assign empty = (commit_q == rd_ptr_q);
    assign drop  = drop_q;

    // Write side: commit on EOF, roll back to the commit point on overflow
    // or on a SOF that interrupts an open frame.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q + PW'(rd_acc);
        commit_d  = commit_q;
        discard_d = discard_q;
        drop_d    = 1'b0;
        wr_we     = 1'b0;
        wr_addr   = wr_ptr_q;
        fc_inc    = 1'b0;
        if (wr_en) begin
            if (discard_q) begin
                // Swallow the rest of the overflowed frame up to its EOF.
                if (eof_in) begin
                    discard_d = 1'b0;
                    drop_d    = 1'b1;
                end
            end else if (full) begin
                wr_ptr_d = commit_q;
                if (eof_in) drop_d    = 1'b1;
                else        discard_d = 1'b1;
            end else begin
                if (sof_in && wr_ptr_q != commit_q) begin
                    // Abandon the open frame; the new one starts in its place.
                    wr_addr = commit_q;
                    drop_d  = 1'b1;
                end
                wr_we    = 1'b1;
                wr_ptr_d = wr_addr + PW'(1);
                if (eof_in) begin
                    commit_d = wr_addr + PW'(1);
                    fc_inc   = 1'b1;
                end
            end
        end
    end

    // Commit/discard/drop state.
    always_ff @(posedge clock) begin
        if (reset) begin
            commit_q  <= '0;
            discard_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            commit_q  <= commit_d;
            discard_q <= discard_d;
            drop_q    <= drop_d;
        end
    end
`else
    // Cut-through: everything written is immediately readable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign drop  = 1'b0;

    // Write side: plain FIFO, writes while full are lost.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q + PW'(rd_acc);
        wr_we    = 1'b0;
        wr_addr  = wr_ptr_q;
        fc_inc   = 1'b0;
        if (wr_en && !full) begin
            wr_we    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            fc_inc   = eof_in;
        end
    end
`endif

    // Saturating frame counter; simultaneous +1/-1 cancel.
    always_comb begin
        fcnt_d = fcnt_q;
        if (fc_inc && !fc_dec && fcnt_q != FC_MAX)
            fcnt_d = fcnt_q + FRAME_CNT_WIDTH'(1);
        else if (fc_dec && !fc_inc && fcnt_q != '0)
            fcnt_d = fcnt_q - FRAME_CNT_WIDTH'(1);
    end

    // Pointer and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // EOF shadow tracks whatever the RAM write port stores.
    always_ff @(posedge clock) begin
        if (wr_we) eof_map_q[wr_addr[AW-1:0]] <= eof_in;
    end

    assign frame_count = fcnt_q;
    assign wr_flags    = '{sof: sof_in, eof: eof_in};

    frame_fifo_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (wr_we),
        .waddr (wr_addr[AW-1:0]),
        .wdata ({wr_flags, din}),
        .re    (rd_acc),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rdata)
    );

    assign {rd_flags, dout} = rdata;
    assign sof_out          = rd_flags.sof;
    assign eof_out          = rd_flags.eof;

endmodule

// File: tb/tb_frame_fifo.sv
// tb_frame_fifo: scoreboard bench for frame_fifo (DEPTH=8, 2-bit frame counter
// so saturation is reachable). Stimulus keeps a FIFO model and queues the
// expected read responses; a negedge monitor pops and compares them.
module tb_frame_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int FCW   = 2;
    localparam int FCMAX = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din   = '0;
    logic          sof_in = 1'b0;
    logic          eof_in = 1'b0;
    logic          rd_en = 1'b0;
    logic          full, empty, sof_out, eof_out, drop;
    logic [DW-1:0] dout;
    logic [3:0]    level;
    logic [FCW-1:0] frame_count;

    frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FRAME_CNT_WIDTH(FCW)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .din(din),
        .sof_in(sof_in), .eof_in(eof_in), .full(full), .rd_en(rd_en),
        .dout(dout), .sof_out(sof_out), .eof_out(eof_out), .empty(empty),
        .level(level), .frame_count(frame_count), .drop(drop)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model state: entries are {sof, eof, data}.
    logic [9:0] mq[$];
    logic [9:0] exp_q[$];
    int         mcommit = 0;
    bit         mdisc   = 1'b0;
    bit         mdrop   = 1'b0;
    int         mfc     = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic status();
        chk("level", int'(level), mq.size());
        chk("empty", int'(empty), int'(mcommit == 0));
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("frame_count", int'(frame_count), mfc);
        chk("drop", int'(drop), int'(mdrop));
    endtask

    task automatic rollback();
        while (mq.size() > mcommit) void'(mq.pop_back());
    endtask

    // One clock: drive inputs, advance the model on pre-edge state, check.
    task automatic cyc(input bit we, input logic [7:0] d, input bit s,
                       input bit e, input bit re);
        bit         full_m, rd_ok, inc, dec;
        logic [9:0] ent;
        wr_en = we; din = d; sof_in = s; eof_in = e; rd_en = re;
        full_m = (mq.size() == DEPTH);
        rd_ok  = re && (mcommit > 0);
        @(posedge clock);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; sof_in = 1'b0; eof_in = 1'b0;
        mdrop = 1'b0; inc = 1'b0; dec = 1'b0;
        if (rd_ok) begin
            ent = mq.pop_front();
            mcommit--;
            exp_q.push_back(ent);
            dec = ent[8];
        end
`ifdef FRAME_DROP_EN
        if (we) begin
            if (mdisc) begin
                if (e) begin mdisc = 1'b0; mdrop = 1'b1; end
            end else if (full_m) begin
                rollback();
                if (e) mdrop = 1'b1;
                else   mdisc = 1'b1;
            end else begin
                if (s && mq.size() > mcommit) begin
                    rollback();
                    mdrop = 1'b1;
                end
                mq.push_back({s, e, d});
                if (e) begin mcommit = mq.size(); inc = 1'b1; end
            end
        end
`else
        if (we && !full_m) begin
            mq.push_back({s, e, d});
            mcommit++;
            inc = e;
        end
`endif
        if (inc && !dec && mfc != FCMAX) mfc++;
        else if (dec && !inc && mfc != 0) mfc--;
        status();
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        mq.delete();
        mcommit = 0; mdisc = 1'b0; mdrop = 1'b0; mfc = 0;
        status();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && mcommit > 0; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: a read fired on the edge before this negedge -> dout must
    // show the next scoreboard entry; otherwise dout holds (or is 0 after reset).
    logic [9:0] last_exp;
    bit have_exp = 1'b0, rd_pend = 1'b0, rst_pend = 1'b0;
    always @(negedge clock) begin
        if (rst_pend) begin
            last_exp = '0;
            have_exp = 1'b1;
        end else if (rd_pend) begin
            if (exp_q.size() == 0) chk("unexpected_read", 1, 0);
            else begin
                last_exp = exp_q.pop_front();
                have_exp = 1'b1;
            end
        end
        if (have_exp) chk("dout", int'({sof_out, eof_out, dout}), int'(last_exp));
        rst_pend = reset;
        rd_pend  = !reset && rd_en && !empty;
    end

    initial begin
        int len;
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // Three-word frame A0..A2, then read it back.
        cyc(1'b1, 8'hA0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Fill to full, overflow write, read/write at and below full.
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 8'(8'h10 + i), i == 0, i == 7, 1'b0);
        cyc(1'b1, 8'h18, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h20, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 8'h21, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
        drain();

        // EOF write and EOF read together with two frames stored.
        cyc(1'b1, 8'h30, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'h31, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'h32, 1'b1, 1'b1, 1'b1);
        drain();

        // Eight single-word frames: counter saturates, then floors at 0.
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b1, 1'b0);
        drain();

        // Twenty random-length frames with random reads.
        for (int f = 0; f < 20; f++) begin
            len = int'($urandom_range(1, 5));
            for (int w = 0; w < len; w++)
                cyc(1'b1, 8'($urandom_range(0, 255)), w == 0, w == len - 1,
                    1'($urandom_range(0, 1)));
        end
        drain();

        // Frame overflowing the FIFO, then a clean 2-word frame.
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h60 + i), i == 0, 1'b0, 1'b0);
        cyc(1'b1, 8'h68, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h69, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'h70, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h71, 1'b0, 1'b1, 1'b0);
        drain();

        // SOF arriving inside an open frame.
        cyc(1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h82, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h83, 1'b0, 1'b1, 1'b0);
        drain();

        // Reset mid-frame with five entries stored.
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h90 + i), i == 0, i == 2, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        do_reset();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        chk("scoreboard_left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
